// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, FSM encoding and widths.
package instr_fetch_unit_pkg;

  localparam int INSTR_W = 32;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_ANDI  = 6'h0C;
  localparam opcode_t OP_ORI   = 6'h0D;
  localparam opcode_t OP_SW    = 6'h10;
  localparam opcode_t OP_LW    = 6'h11;
  localparam opcode_t OP_BEQ   = 6'h13;
  localparam opcode_t OP_J     = 6'h1C;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  function automatic logic is_legal_op(input opcode_t op);
    case (op)
      OP_RTYPE, OP_ANDI, OP_ORI, OP_SW, OP_LW, OP_BEQ, OP_J: is_legal_op = 1'b1;
      default:                                             is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory req/ack bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection: jump target, taken branch, or sequential pc+4 (Jump has priority).
module next_pc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_imm,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] next_pc
);

  logic signed [31:0] br_off;

  assign br_off = {{14{instr_imm[15]}}, instr_imm[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (Jump)
      next_pc = {pc_plus4[31:28], instr_imm, 2'b00};
    else if (Branch && Zero)
      next_pc = pc_plus4 + $unsigned(br_off);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack FSM, instruction latch and retire counter.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master imem,
  input  logic               stall,
  input  logic               Branch,
  input  logic               Jump,
  input  logic               Zero,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         Opcode,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               halted,
  output logic [31:0]        retire_cnt
);

  logic [1:0]  state;
  logic [31:0] calc_pc;
  logic [31:0] next_pc;
  logic        op_legal;

  assign Opcode         = instr[31:26];
  assign pc_plus4       = pc + 32'd4;
  assign imem.imem_addr = {pc[31:2], 2'b00};
  assign op_legal       = is_legal_op(Opcode);

  next_pc_calc u_next_pc (
    .pc_plus4  (pc_plus4),
    .instr_imm (instr[25:0]),
    .Branch    (Branch),
    .Jump      (Jump),
    .Zero      (Zero),
    .next_pc   (calc_pc)
  );

  // With halting disabled an unsupported opcode falls through as a plain sequential NOP.
  assign next_pc = op_legal ? calc_pc : pc_plus4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      instr         <= '0;
      instr_valid   <= 1'b0;
      imem.imem_req <= 1'b0;
      halted        <= 1'b0;
      retire_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state         <= S_REQ;
          imem.imem_req <= 1'b1;
        end
        S_REQ: begin
          if (imem.imem_ack) begin
            instr         <= imem.imem_rdata;
            instr_valid   <= 1'b1;
            imem.imem_req <= 1'b0;
            state         <= S_VALID;
          end
        end
        S_VALID: begin
          if (!stall) begin
            retire_cnt  <= retire_cnt + 32'd1;
            instr_valid <= 1'b0;
            if (ILLEGAL_HALT && !op_legal) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              pc            <= next_pc;
              imem.imem_req <= 1'b1;
              state         <= S_REQ;
            end
          end
        end
        S_HALT: begin
          imem.imem_req <= 1'b0;
          instr_valid   <= 1'b0;
          halted        <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit against a behavioural PC model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, Branch, Jump, Zero;
  logic [31:0] instr, pc, pc_plus4, retire_cnt;
  logic [5:0]  Opcode;
  logic        instr_valid, halted;

  int          vectors = 0;
  int          fails   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_retire;
  logic [5:0]  legal_ops [7] = '{6'h00, 6'h0C, 6'h0D, 6'h10, 6'h11, 6'h13, 6'h1C};

  always #5 clk = ~clk;

  instr_fetch_unit_if imem_bus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .ILLEGAL_HALT(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus.master),
    .stall       (stall),
    .Branch      (Branch),
    .Jump        (Jump),
    .Zero        (Zero),
    .instr       (instr),
    .Opcode      (Opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .halted      (halted),
    .retire_cnt  (retire_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit op_is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference next address from plain arithmetic on the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] iw,
                                             input logic br, input logic j, input logic z);
    logic [31:0] seq;
    logic [15:0] imm;
    seq = cur_pc + 32'd4;
    imm = iw[15:0];
    if (j) return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
    if (br && z) return seq + 32'(int'($signed(imm)) * 4);
    return seq;
  endfunction

  task automatic release_reset();
    rst = 1'b0;
    chk("idle_no_req", {31'b0, imem_bus.imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("first_req", {31'b0, imem_bus.imem_req}, 32'd1);
    chk("first_addr", imem_bus.imem_addr, 32'h0000_0000);
    exp_pc     = 32'h0000_0000;
    exp_retire = 32'd0;
  endtask

  task automatic fetch(input logic [31:0] data, input int waits, input int stalls,
                       input logic br, input logic j, input logic z);
    int n;
    n = 0;
    while (imem_bus.imem_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_asserted", {31'b0, imem_bus.imem_req}, 32'd1);
    chk("fetch_addr", imem_bus.imem_addr, exp_pc);
    for (int w = 0; w < waits; w++) begin
      @(posedge clk); #1;
      chk("req_held", {31'b0, imem_bus.imem_req}, 32'd1);
      chk("addr_stable", imem_bus.imem_addr, exp_pc);
      chk("valid_low_in_wait", {31'b0, instr_valid}, 32'd0);
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = data;
    @(posedge clk); #1;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = $urandom;
    chk("instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("instr", instr, data);
    chk("opcode", {26'b0, Opcode}, {26'b0, data[31:26]});
    chk("pc", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    chk("req_low_valid", {31'b0, imem_bus.imem_req}, 32'd0);
    for (int s = 0; s < stalls; s++) begin
      stall             = 1'b1;
      Branch            = 1'($urandom);
      Jump              = 1'($urandom);
      Zero              = 1'($urandom);
      imem_bus.imem_ack = 1'($urandom);
      @(posedge clk); #1;
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instr, data);
      chk("stall_pc", pc, exp_pc);
      chk("stall_no_req", {31'b0, imem_bus.imem_req}, 32'd0);
      chk("stall_retire", retire_cnt, exp_retire);
    end
    imem_bus.imem_ack = 1'b0;
    stall  = 1'b0;
    Branch = br;
    Jump   = j;
    Zero   = z;
    @(posedge clk); #1;
    Branch = 1'($urandom);
    Jump   = 1'($urandom);
    Zero   = 1'($urandom);
    exp_retire = exp_retire + 32'd1;
    chk("retire_cnt", retire_cnt, exp_retire);
    chk("valid_dropped", {31'b0, instr_valid}, 32'd0);
    if (!op_is_legal(data[31:26])) begin
      chk("halted_set", {31'b0, halted}, 32'd1);
      chk("halt_no_req", {31'b0, imem_bus.imem_req}, 32'd0);
      chk("halt_pc_kept", pc, exp_pc);
    end else begin
      exp_pc = model_next(exp_pc, data, br, j, z);
      chk("next_req", {31'b0, imem_bus.imem_req}, 32'd1);
      chk("next_addr", imem_bus.imem_addr, exp_pc);
      chk("not_halted", {31'b0, halted}, 32'd0);
    end
  endtask

  initial begin
    logic [5:0] op;
    rst = 1'b1;
    stall = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
    chk("rst_addr", imem_bus.imem_addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    release_reset();

    fetch(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0);  // pc 0 -> 4
    fetch(32'h3000_0001, 3, 0, 1'b0, 1'b0, 1'b0);  // wait states, -> 8
    fetch(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);  // -> 0xC
    fetch(32'h0000_0000, 1, 0, 1'b0, 1'b0, 1'b0);  // -> 0x10
    fetch(32'h4C00_0003, 0, 0, 1'b1, 1'b0, 1'b1);  // taken -> 0x20
    fetch(32'h4C00_0003, 0, 0, 1'b1, 1'b0, 1'b0);  // not taken -> 0x24
    fetch(32'h4C00_FFFF, 0, 0, 1'b1, 1'b0, 1'b1);  // offset -1 -> 0x24
    fetch(32'h0000_0000, 0, 5, 1'b0, 1'b0, 1'b0);  // 5-cycle stall -> 0x28
    fetch(32'h7000_0010, 0, 0, 1'b0, 1'b1, 1'b0);  // jump -> 0x40
    fetch(32'h4C00_FFEB, 0, 0, 1'b1, 1'b0, 1'b1);  // -> 0xFFFF_FFF0
    repeat (4) fetch(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);  // wraps to 0
    fetch(32'h4C00_FFFB, 0, 0, 1'b1, 1'b0, 1'b1);  // -> 0xFFFF_FFF0
    fetch(32'h7000_0010, 0, 0, 1'b1, 1'b1, 1'b1);  // jump wins -> 0xF000_0040

    for (int k = 0; k < 40; k++) begin
      op = legal_ops[$urandom_range(0, 6)];
      fetch({op, 26'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 2),
            1'($urandom), 1'($urandom), 1'($urandom));
    end

    fetch(32'hFC00_0000, 0, 0, 1'b0, 1'b0, 1'b0);  // illegal opcode halts
    for (int h = 0; h < 5; h++) begin
      imem_bus.imem_ack = 1'($urandom);
      @(posedge clk); #1;
      chk("halt_hold_req", {31'b0, imem_bus.imem_req}, 32'd0);
      chk("halt_hold_flag", {31'b0, halted}, 32'd1);
      chk("halt_hold_retire", retire_cnt, exp_retire);
    end
    imem_bus.imem_ack = 1'b0;

    // Reset mid-wait: abandon a pending fetch, ignore an ack that lands during reset.
    rst = 1'b1;
    @(posedge clk); #1;
    release_reset();
    fetch(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("pending_req", {31'b0, imem_bus.imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_retire", retire_cnt, 32'd0);
    chk("async_rst_halted", {31'b0, halted}, 32'd0);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    imem_bus.imem_ack = 1'b0;
    chk("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    chk("late_ack_instr", instr, 32'h0);
    release_reset();
    fetch(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
